// File: rtl/fsm_multi_pkg.sv
// Shared types for the multi-channel packet-framing monitor.
package fsm_multi_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    HEAD = 3'd1,
    DATA = 3'd2,
    TAIL = 3'd3,
    ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/fsm_chan.sv
// One framing-monitor lane: tracks head/data/tail framing, packet length,
// completion/error pulses and the per-lane packet and error counters.
module fsm_chan
  import fsm_multi_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               head,
  input  logic               tail,
  input  logic               valid,
  output logic [STATE_W-1:0] state,
  output logic               pkt_done,
  output logic               err,
  output logic [LEN_W-1:0]   pkt_len,
  output logic [CNT_W-1:0]   pkt_count,
  output logic [CNT_W-1:0]   err_count
);

  state_t           cur;
  logic [LEN_W-1:0] len;
  logic             in_packet;

  assign state     = cur;
  assign in_packet = (cur == HEAD) || (cur == DATA);

  // A head beat outside a packet always opens a new one (this is also the
  // only way out of ERR); inside a packet the overlength check wins over tail.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cur       <= IDLE;
      len       <= '0;
      pkt_len   <= '0;
      pkt_done  <= 1'b0;
      err       <= 1'b0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      pkt_done <= 1'b0;
      err      <= 1'b0;
      if (valid) begin
        if (head && !in_packet) begin
          len <= LEN_W'(1);
          if (tail) begin
            cur       <= TAIL;
            pkt_done  <= 1'b1;
            pkt_len   <= LEN_W'(1);
            pkt_count <= pkt_count + 1'b1;
          end else begin
            cur <= HEAD;
          end
        end else if (cur == ERR) begin
          cur <= ERR;
        end else if (head || !in_packet || len == LEN_W'(MAX_LEN)) begin
          cur <= ERR;
          err <= 1'b1;
          if (err_count != '1) err_count <= err_count + 1'b1;
        end else begin
          len <= len + 1'b1;
          if (tail) begin
            cur       <= TAIL;
            pkt_done  <= 1'b1;
            pkt_len   <= len + 1'b1;
            pkt_count <= pkt_count + 1'b1;
          end else begin
            cur <= DATA;
          end
        end
      end else if (cur == TAIL) begin
        cur <= IDLE;
      end
    end
  end

endmodule

// File: rtl/fsm_multi.sv
// Multi-channel packet-framing monitor: CHANNELS independent fsm_chan lanes
// with their outputs packed lane-by-lane into flat vectors.
module fsm_multi
  import fsm_multi_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 8,
  parameter int CNT_W    = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         head,
  input  logic [CHANNELS-1:0]         tail,
  input  logic [CHANNELS-1:0]         valid,
  output logic [STATE_W*CHANNELS-1:0] state,
  output logic [CHANNELS-1:0]         pkt_done,
  output logic [LEN_W*CHANNELS-1:0]   pkt_len,
  output logic [CHANNELS-1:0]         err,
  output logic [CNT_W*CHANNELS-1:0]   pkt_count,
  output logic [CNT_W*CHANNELS-1:0]   err_count
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    fsm_chan #(
      .MAX_LEN(MAX_LEN),
      .LEN_W  (LEN_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .head     (head[i]),
      .tail     (tail[i]),
      .valid    (valid[i]),
      .state    (state[STATE_W*i +: STATE_W]),
      .pkt_done (pkt_done[i]),
      .err      (err[i]),
      .pkt_len  (pkt_len[LEN_W*i +: LEN_W]),
      .pkt_count(pkt_count[CNT_W*i +: CNT_W]),
      .err_count(err_count[CNT_W*i +: CNT_W])
    );
  end

endmodule

// File: doc/fsm_multi.md
# fsm_multi

- Parametrised, multi-channel packet-framing monitor; successor to the single-channel two-instance `fsm` arrangement.
- Each of `CHANNELS` independent lanes tracks head/data/tail framing, measures packet length and flags protocol violations.
- Per-lane outputs: state, done/error pulses, and packet and error counters.
- Sits beside the packet datapath as a coverage and checking target; it never back-pressures the source.

## Interface

Parameters:
- `CHANNELS`, default 2: number of independent lanes.
- `MAX_LEN`, default 16: maximum legal beats per packet, head and tail included. Must be ≥1.
- `LEN_W`, default 8: width of the length counter/output. Must satisfy `2**LEN_W > MAX_LEN`.
- `CNT_W`, default 16: width of the packet and error counters.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous reset, active-low.
- `head`  in  CHANNELS  per-lane first-beat marker; qualified by `valid`.
- `tail`  in  CHANNELS  per-lane last-beat marker; qualified by `valid`.
- `valid`  in  CHANNELS  per-lane beat-valid.
- `state`  out  3*CHANNELS  per-lane state code; lane i occupies bits [3i+2:3i].
- `pkt_done`  out  CHANNELS  one-cycle pulse when a lane enters TAIL.
- `pkt_len`  out  LEN_W*CHANNELS  beat count of the last completed packet per lane.
- `err`  out  CHANNELS  one-cycle pulse when a lane enters ERR.
- `pkt_count`  out  CNT_W*CHANNELS  completed packets per lane; wraps.
- `err_count`  out  CNT_W*CHANNELS  error entries per lane; saturates at all-ones.

## Operation

**States:** IDLE=0, HEAD=1, DATA=2, TAIL=3, ERR=4; codes 5–7 unused. A beat is a cycle with `valid[i]`=1. `head`/`tail` are ignored when `valid`=0.

**Transitions per lane:**
- IDLE/TAIL:
  - beat with head&tail → TAIL, len=1 (single-beat packet).
  - beat with head → HEAD, len=1.
  - beat without head → ERR (orphan data).
  - no beat → IDLE.
- HEAD/DATA:
  - no beat → hold state (stall).
  - beat with head → ERR (nested head).
  - beat with len=MAX_LEN → ERR (overlength; this check has priority over tail).
  - beat with tail → TAIL, len+1.
  - other beat → DATA, len+1.
- ERR:
  - beat with head&tail → TAIL, len=1.
  - beat with head → HEAD, len=1.
  - anything else → ERR; len is held.
  - ERR is exited only by a head beat.

**Per-lane outputs:**
- On entry to TAIL: `pkt_done`=1, `pkt_len` ← new len, `pkt_count` += 1 (mod 2^CNT_W).
- On entry to ERR: `err`=1, `err_count` += 1 unless already all-ones. `pkt_len` is unchanged.

**Lane independence:** lanes share no state; simultaneous events on different lanes are all processed in the same cycle.

## Timing

- All outputs are registered. Inputs sampled at edge N are reflected in `state`, `pkt_done`, `err`, `pkt_len` and the counters from edge N onward, i.e. readable in cycle N+1. Latency is 1 cycle.
- `pkt_done` and `err` are high for exactly one cycle per entry.
- Back-to-back packets (TAIL→TAIL or TAIL→HEAD) produce one `pkt_done` per packet with no idle cycle required.
- A stall (`valid`=0) in HEAD/DATA does not advance len and causes no error.
- Reset (`reset`=0 at an edge) forces, on every lane: state=IDLE, len=0, `pkt_len`=0, `pkt_done`=0, `err`=0, `pkt_count`=0, `err_count`=0.
  - Applies mid-packet too; the partial packet is discarded with no pulse.
  - Inputs are ignored while `reset`=0.
  - The first edge with `reset`=1 evaluates inputs normally.

## Structure

- Package `fsm_multi_pkg` holds the state enum (3-bit, codes above) and the state-code width constant.
- Sub-module `fsm_chan` implements one lane: state, len, `pkt_len`, both counters and the pulses. It is parametrised by `MAX_LEN`, `LEN_W` and `CNT_W`.
- `fsm_multi` is a generate loop of `CHANNELS` `fsm_chan` instances plus vector slicing; it contains no other logic.

## Test plan

1. **Reset, then basic packet.** Lane 0 drives head+valid, then tail+valid, then valid=0.
   - States: IDLE→HEAD→TAIL→IDLE.
   - `pkt_done[0]` pulses once; `pkt_len[0]`=2; `pkt_count[0]`=1.
   - Lane 1 stays IDLE with all counters 0.
2. **Stalls and single-beat packet.** Lane 1 drives head, valid=0 ×3, data, tail, then head&tail.
   - `pkt_len[1]`=3, then 1.
   - `pkt_count[1]`=2; `err`=0 throughout.
3. **Violations.**
   - Orphan data in IDLE → ERR, `err` pulse, `err_count`=1.
   - Non-head beats hold ERR with no further pulses.
   - A head beat recovers to HEAD.
   - Nested head in DATA → ERR, `err_count`=2.
4. **Overlength.** `MAX_LEN`=4: head + 3 data beats, then a tail beat.
   - Tail beat (5th beat) → ERR, not TAIL; `pkt_count` unchanged.
   - Head + 2 data + tail (4 beats) → TAIL with `pkt_len`=4.
5. **Reset mid-packet.** Lane 0 in DATA with len=3; assert `reset`=0 for one edge.
   - All outputs return to 0/IDLE with no `pkt_done`.
   - The next head starts len at 1.
6. **Counter limits.** `CNT_W`=2.
   - Five packets → `pkt_count`=1 (wrap).
   - Five errors → `err_count`=3 (saturated).
   - `CHANNELS`=4 with simultaneous traffic on all lanes gives independent per-lane results.
